pe_array_stu_arbiter: RTL and testbench
=======================================

# pe_array_stu_arbiter

Parametrised upstream stack-bus concentrator for the PE array. It merges the per-PE `pe__stu__*` streams from `NUM_PE` PEs into one upstream stack-bus port. Each PE gets its own input FIFO, and arbitration is round-robin and packet-atomic. Each word is tagged with the source PE id and the merged stream is presented upstream. The block sits in the PE array top, between the PE generate loop and the system upstream stack-bus connections, and replaces the fixed per-PE wiring.

## Interface
Parameters:
- `NUM_PE`, 64, number of PE channels (2..256)
- `DATA_W`, 64, `pe__stu__data` width
- `OOB_W`, 32, `pe__stu__oob_data` width
- `TYPE_W`, 2, `pe__stu__type` width
- `FIFO_DEPTH`, 4, words per PE FIFO (power of 2, ≥2)
- `ID_W`, `$clog2(NUM_PE)`, PE id width

Ports (clock and reset first; reset is asynchronous and active-high):
- `clk`  in  1  sole clock, rising edge
- `reset_poweron`  in  1  asynchronous, active-high reset
- `pe__stu__valid`  in  NUM_PE  per-PE word valid
- `pe__stu__cntl`  in  2*NUM_PE  per-PE cntl: 01 SOM, 00 MOM, 10 EOM, 11 SOM_EOM
- `pe__stu__type`  in  TYPE_W*NUM_PE  per-PE type
- `pe__stu__data`  in  DATA_W*NUM_PE  per-PE data
- `pe__stu__oob_data`  in  OOB_W*NUM_PE  per-PE OOB data
- `stu__pe__ready`  out  NUM_PE  per-PE ready (FIFO not full)
- `stu__sys__valid`  out  1  merged word valid
- `stu__sys__cntl`  out  2  merged cntl
- `stu__sys__type`  out  TYPE_W  merged type
- `stu__sys__data`  out  DATA_W  merged data
- `stu__sys__oob_data`  out  OOB_W  merged OOB data
- `stu__sys__pe_id`  out  ID_W  source PE of the current word
- `sys__stu__ready`  in  1  upstream ready
- `stu__sys__proto_err`  out  1  sticky protocol error
- `stu__sys__err_pe_id`  out  ID_W  PE id of the first error
- `stu__sys__idle`  out  1  all FIFOs empty, FSM in ARB, output register empty

## Operation
- Input channel i: a word transfers when `pe__stu__valid[i] & stu__pe__ready[i]` at a rising edge; it is written to FIFO i. `stu__pe__ready[i]` = FIFO i not full. It is registered, not combinational on the valid.
- FSM states:
  - ARB: scan FIFO heads starting at `rr_ptr`, wrapping modulo NUM_PE. The first non-empty head whose cntl is SOM or SOM_EOM becomes `grant`; next state XFER. A non-empty head with MOM or EOM is a protocol error: pop and drop it, set the sticky error and latch that PE id if no error is already latched.
  - XFER: pop FIFO[`grant`] into the output register whenever the register is empty or is being drained in that cycle. After popping EOM or SOM_EOM, return to ARB and set `rr_ptr = (grant+1) mod NUM_PE`.
- An empty granted FIFO mid-packet inserts bubbles; the grant is held with no timeout.
- A SOM popped in XFER (before EOM) sets `proto_err` and is forwarded unchanged.
- Output handshake: a word transfers on `stu__sys__valid & sys__stu__ready`. While valid is high and ready is low, all `stu__sys__*` outputs hold stable.
- `proto_err` clears only on reset.

## Timing
- Reset (async assert, sync-released use):
  - all `stu__sys__*` outputs = 0, `stu__pe__ready` = 0, FIFOs empty, FSM = ARB, `rr_ptr` = 0, `idle` = 0.
  - On the first edge after deassertion: `stu__pe__ready` = all 1s, `idle` = 1.
- Latency: word accepted at edge E0; grant latched at E1; output register loaded at E2; `stu__sys__valid` is high from E2 on.
- Throughput: 1 word/cycle within a packet when the FIFO is fed and ready is high.
- Inter-packet gap: 1 ARB cycle.
- Simultaneous write and read on a full FIFO: the read frees a slot next cycle only; `ready` is from registered occupancy, so there is no same-cycle write.
- Reset mid-packet: the partial packet is discarded, with no EOM emitted.

## Structure
- Package `pe_array_stu_pkg` holds:
  - cntl encodings `STU_CNTL_SOM/MOM/EOM/SOM_EOM`
  - FSM state typedef {ARB, XFER}
  - default width constants
- Sub-module `pe_array_stu_fifo`: a single-clock synchronous FIFO instantiated NUM_PE times. It has width `2+TYPE_W+DATA_W+OOB_W` and depth `FIFO_DEPTH`, and outputs full/empty plus the head word.
- Top level: round-robin priority scan, FSM, output register and error logic.

## Test plan
- PE 3 sends a SOM_EOM word with data 0xA5, upstream ready held at 1 → valid rises 2 cycles after accept, `pe_id` = 3, `idle` returns to 1.
- PEs 0 and 1 each send a 3-word packet in the same cycle → output is PE0 words 0..2, then PE1 words 0..2, never interleaved; after that `rr_ptr` = 2.
- Upstream ready is low for 10 cycles mid-packet → outputs stay stable. PE FIFO fills, `stu__pe__ready` drops after 4 accepted words (FIFO_DEPTH = 4). No words are lost after ready returns.
- PE 5 sends MOM with no preceding SOM → the word is dropped, `proto_err` = 1, `err_pe_id` = 5. A later valid packet from PE 5 passes normally.
- Reset asserted on the 2nd word of a 4-word packet → outputs go 0 asynchronously. After release, FIFOs are empty, `idle` = 1, and a new packet works.
- NUM_PE = 4: all PEs send continuously → grants rotate 0,1,2,3,0; each PE is served within 3 packets of requesting.

Source files
------------

// File: rtl/pe_array_stu_pkg.sv
// ============================================================================
// pe_array_stu_pkg : shared encodings, FSM states and default widths
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_array_stu_pkg;

  localparam logic [1:0] STU_CNTL_MOM     = 2'b00;
  localparam logic [1:0] STU_CNTL_SOM     = 2'b01;
  localparam logic [1:0] STU_CNTL_EOM     = 2'b10;
  localparam logic [1:0] STU_CNTL_SOM_EOM = 2'b11;

  typedef logic [0:0] stu_state_t;
  localparam stu_state_t STU_ARB  = 1'b0;
  localparam stu_state_t STU_XFER = 1'b1;

  localparam int STU_DEF_NUM_PE     = 64;
  localparam int STU_DEF_DATA_W     = 64;
  localparam int STU_DEF_OOB_W      = 32;
  localparam int STU_DEF_TYPE_W     = 2;
  localparam int STU_DEF_FIFO_DEPTH = 4;

  function automatic logic cntl_is_som(input logic [1:0] c);
    return (c == STU_CNTL_SOM) || (c == STU_CNTL_SOM_EOM);
  endfunction

  function automatic logic cntl_is_eom(input logic [1:0] c);
    return (c == STU_CNTL_EOM) || (c == STU_CNTL_SOM_EOM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_array_stu_fifo.sv
// ============================================================================
// pe_array_stu_fifo : single-clock synchronous FIFO with show-ahead head word
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_array_stu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/pe_array_stu_arbiter.sv
// ============================================================================
// pe_array_stu_arbiter : per-PE FIFOs merged upstream with round-robin,
// packet-atomic arbitration, PE id tagging and sticky protocol-error capture.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_array_stu_arbiter
  import pe_array_stu_pkg::*;
#(
  parameter int NUM_PE     = STU_DEF_NUM_PE,
  parameter int DATA_W     = STU_DEF_DATA_W,
  parameter int OOB_W      = STU_DEF_OOB_W,
  parameter int TYPE_W     = STU_DEF_TYPE_W,
  parameter int FIFO_DEPTH = STU_DEF_FIFO_DEPTH,
  parameter int ID_W       = $clog2(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     reset_poweron,
  input  logic [NUM_PE-1:0]        pe__stu__valid,
  input  logic [2*NUM_PE-1:0]      pe__stu__cntl,
  input  logic [TYPE_W*NUM_PE-1:0] pe__stu__type,
  input  logic [DATA_W*NUM_PE-1:0] pe__stu__data,
  input  logic [OOB_W*NUM_PE-1:0]  pe__stu__oob_data,
  output logic [NUM_PE-1:0]        stu__pe__ready,
  output logic                     stu__sys__valid,
  output logic [1:0]               stu__sys__cntl,
  output logic [TYPE_W-1:0]        stu__sys__type,
  output logic [DATA_W-1:0]        stu__sys__data,
  output logic [OOB_W-1:0]         stu__sys__oob_data,
  output logic [ID_W-1:0]          stu__sys__pe_id,
  input  logic                     sys__stu__ready,
  output logic                     stu__sys__proto_err,
  output logic [ID_W-1:0]          stu__sys__err_pe_id,
  output logic                     stu__sys__idle
);

  localparam int WORD_W = 2 + TYPE_W + DATA_W + OOB_W;

  logic              live;
  logic [NUM_PE-1:0] fifo_full;
  logic [NUM_PE-1:0] fifo_empty;
  logic [NUM_PE-1:0] push;
  logic [NUM_PE-1:0] pop;
  logic [WORD_W-1:0] heads [NUM_PE];

  stu_state_t        state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr_ptr;
  logic              first_word;

  logic              found;
  logic [ID_W-1:0]   scan_idx;
  logic [ID_W-1:0]   scan_try;
  logic [1:0]        scan_cntl;
  logic [WORD_W-1:0] grant_head;
  logic [1:0]        grant_cntl;
  logic              arb_take;
  logic              arb_drop;
  logic              load;
  logic              err_hit;
  logic [ID_W-1:0]   err_src;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PE) s = s - NUM_PE;
    return ID_W'(s);
  endfunction

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    // Ready comes only from registered occupancy, held low until after reset.
    assign stu__pe__ready[i] = live & ~fifo_full[i];
    assign push[i]           = pe__stu__valid[i] & stu__pe__ready[i];

    pe_array_stu_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (reset_poweron),
      .push  (push[i]),
      .wdata ({pe__stu__cntl[2*i +: 2], pe__stu__type[TYPE_W*i +: TYPE_W],
               pe__stu__data[DATA_W*i +: DATA_W], pe__stu__oob_data[OOB_W*i +: OOB_W]}),
      .pop   (pop[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .head  (heads[i])
    );
  end

  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    scan_try = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      scan_try = wrap_add(rr_ptr, k);
      if (!found && !fifo_empty[scan_try]) begin
        found    = 1'b1;
        scan_idx = scan_try;
      end
    end
  end

  assign scan_cntl  = heads[scan_idx][WORD_W-1 -: 2];
  assign grant_head = heads[grant];
  assign grant_cntl = grant_head[WORD_W-1 -: 2];

  assign arb_take = (state == STU_ARB) && found && cntl_is_som(scan_cntl);
  assign arb_drop = (state == STU_ARB) && found &&
                    ((scan_cntl == STU_CNTL_MOM) || (scan_cntl == STU_CNTL_EOM));
  assign load     = (state == STU_XFER) && !fifo_empty[grant] &&
                    (!stu__sys__valid || sys__stu__ready);

  // A start marker after the packet's first word means a PE restarted mid-packet.
  assign err_hit = arb_drop || (load && !first_word && cntl_is_som(grant_cntl));
  assign err_src = arb_drop ? scan_idx : grant;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      pop[i] = (arb_drop && (scan_idx == ID_W'(i))) || (load && (grant == ID_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      live                <= 1'b0;
      state               <= STU_ARB;
      grant               <= '0;
      rr_ptr              <= '0;
      first_word          <= 1'b0;
      stu__sys__proto_err <= 1'b0;
      stu__sys__err_pe_id <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        STU_ARB: begin
          if (arb_take) begin
            grant      <= scan_idx;
            first_word <= 1'b1;
            state      <= STU_XFER;
          end
        end
        STU_XFER: begin
          if (load) begin
            first_word <= 1'b0;
            if (cntl_is_eom(grant_cntl)) begin
              state  <= STU_ARB;
              rr_ptr <= wrap_add(grant, 1);
            end
          end
        end
        default: state <= STU_ARB;
      endcase
      if (err_hit) begin
        stu__sys__proto_err <= 1'b1;
        if (!stu__sys__proto_err) stu__sys__err_pe_id <= err_src;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      stu__sys__valid    <= 1'b0;
      stu__sys__cntl     <= '0;
      stu__sys__type     <= '0;
      stu__sys__data     <= '0;
      stu__sys__oob_data <= '0;
      stu__sys__pe_id    <= '0;
    end else if (load) begin
      stu__sys__valid    <= 1'b1;
      stu__sys__cntl     <= grant_cntl;
      stu__sys__type     <= grant_head[WORD_W-3 -: TYPE_W];
      stu__sys__data     <= grant_head[DATA_W+OOB_W-1 -: DATA_W];
      stu__sys__oob_data <= grant_head[OOB_W-1:0];
      stu__sys__pe_id    <= grant;
    end else if (sys__stu__ready) begin
      stu__sys__valid <= 1'b0;
    end
  end

  assign stu__sys__idle = live && (&fifo_empty) && (state == STU_ARB) && !stu__sys__valid;

endmodule

`default_nettype wire

// File: tb/tb_pe_array_stu_arbiter.sv
// ============================================================================
// tb_pe_array_stu_arbiter : directed self-checking bench for the stack-bus concentrator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_array_stu_arbiter;
  import pe_array_stu_pkg::*;

  localparam int NP = 8;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int TW = 2;
  localparam int FD = 4;
  localparam int IW = 3;

  logic             clk;
  logic             reset_poweron;
  logic [NP-1:0]    pe__stu__valid;
  logic [2*NP-1:0]  pe__stu__cntl;
  logic [TW*NP-1:0] pe__stu__type;
  logic [DW*NP-1:0] pe__stu__data;
  logic [OW*NP-1:0] pe__stu__oob_data;
  logic [NP-1:0]    stu__pe__ready;
  logic             stu__sys__valid;
  logic [1:0]       stu__sys__cntl;
  logic [TW-1:0]    stu__sys__type;
  logic [DW-1:0]    stu__sys__data;
  logic [OW-1:0]    stu__sys__oob_data;
  logic [IW-1:0]    stu__sys__pe_id;
  logic             sys__stu__ready;
  logic             stu__sys__proto_err;
  logic [IW-1:0]    stu__sys__err_pe_id;
  logic             stu__sys__idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    cntl;
    logic [DW-1:0] data;
  } word_t;
  word_t got[$];

  pe_array_stu_arbiter #(
    .NUM_PE(NP), .DATA_W(DW), .OOB_W(OW), .TYPE_W(TW), .FIFO_DEPTH(FD), .ID_W(IW)
  ) dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .pe__stu__valid      (pe__stu__valid),
    .pe__stu__cntl       (pe__stu__cntl),
    .pe__stu__type       (pe__stu__type),
    .pe__stu__data       (pe__stu__data),
    .pe__stu__oob_data   (pe__stu__oob_data),
    .stu__pe__ready      (stu__pe__ready),
    .stu__sys__valid     (stu__sys__valid),
    .stu__sys__cntl      (stu__sys__cntl),
    .stu__sys__type      (stu__sys__type),
    .stu__sys__data      (stu__sys__data),
    .stu__sys__oob_data  (stu__sys__oob_data),
    .stu__sys__pe_id     (stu__sys__pe_id),
    .sys__stu__ready     (sys__stu__ready),
    .stu__sys__proto_err (stu__sys__proto_err),
    .stu__sys__err_pe_id (stu__sys__err_pe_id),
    .stu__sys__idle      (stu__sys__idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words that will transfer upstream at the coming rising edge.
  always @(negedge clk) begin
    word_t w;
    if (!reset_poweron && stu__sys__valid && sys__stu__ready) begin
      w.id   = stu__sys__pe_id;
      w.cntl = stu__sys__cntl;
      w.data = stu__sys__data;
      got.push_back(w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pe(input int p, input logic v, input logic [1:0] c, input logic [DW-1:0] d);
    logic [31:0] pv;
    pv = p;
    pe__stu__valid[p]            = v;
    pe__stu__cntl[2*p +: 2]      = c;
    pe__stu__type[TW*p +: TW]    = pv[1:0];
    pe__stu__data[DW*p +: DW]    = d;
    pe__stu__oob_data[OW*p +: OW] = d[7:0];
  endtask

  function automatic logic [1:0] pkt_cntl(input int k, input int n);
    if (n == 1)     return STU_CNTL_SOM_EOM;
    if (k == 0)     return STU_CNTL_SOM;
    if (k == n - 1) return STU_CNTL_EOM;
    return STU_CNTL_MOM;
  endfunction

  task automatic wait_idle(input string tag, input int maxc);
    int c;
    c = 0;
    while (!stu__sys__idle && c < maxc) begin
      tick();
      c++;
    end
    chk({tag, "_idle"}, stu__sys__idle, 1);
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [IW-1:0] id,
                          input logic [DW-1:0] d);
    if (idx >= got.size()) begin
      chk({tag, "_missing"}, got.size(), idx + 1);
    end else begin
      chk({tag, "_id"}, got[idx].id, id);
      chk({tag, "_data"}, got[idx].data, d);
    end
  endtask

  initial begin
    int n;
    int bad;
    int guard;
    reset_poweron     = 1'b1;
    pe__stu__valid    = '0;
    pe__stu__cntl     = '0;
    pe__stu__type     = '0;
    pe__stu__data     = '0;
    pe__stu__oob_data = '0;
    sys__stu__ready   = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", stu__pe__ready, 0);
    chk("rst_valid", stu__sys__valid, 0);
    chk("rst_idle", stu__sys__idle, 0);
    chk("rst_err", stu__sys__proto_err, 0);
    reset_poweron = 1'b0;
    chk("rel_ready_pre", stu__pe__ready, 0);
    tick();
    chk("rel_ready", stu__pe__ready, 8'hFF);
    chk("rel_idle", stu__sys__idle, 1);

    // Single SOM_EOM from PE 3: valid two edges after acceptance
    got.delete();
    set_pe(3, 1'b1, STU_CNTL_SOM_EOM, 16'h00A5);
    tick();
    set_pe(3, 1'b0, 2'b00, '0);
    chk("t1_e0_valid", stu__sys__valid, 0);
    tick();
    chk("t1_e1_valid", stu__sys__valid, 0);
    tick();
    chk("t1_e2_valid", stu__sys__valid, 1);
    chk("t1_pe_id", stu__sys__pe_id, 3);
    chk("t1_data", stu__sys__data, 16'h00A5);
    chk("t1_cntl", stu__sys__cntl, STU_CNTL_SOM_EOM);
    chk("t1_type", stu__sys__type, 3);
    chk("t1_oob", stu__sys__oob_data, 8'hA5);
    tick();
    chk("t1_idle", stu__sys__idle, 1);

    // PEs 0 and 1 send 3-word packets together: no interleaving
    got.delete();
    for (int k = 0; k < 3; k++) begin
      set_pe(0, 1'b1, pkt_cntl(k, 3), 16'h0100 + 16'(k));
      set_pe(1, 1'b1, pkt_cntl(k, 3), 16'h0110 + 16'(k));
      tick();
    end
    set_pe(0, 1'b0, 2'b00, '0);
    set_pe(1, 1'b0, 2'b00, '0);
    wait_idle("t2", 60);
    chk("t2_count", got.size(), 6);
    for (int k = 0; k < 3; k++) begin
      chk_word("t2_pe0", k, 3'd0, 16'h0100 + 16'(k));
      chk_word("t2_pe1", k + 3, 3'd1, 16'h0110 + 16'(k));
    end
    chk("t2_rr_ptr", dut.rr_ptr, 2);

    // Upstream back-pressure mid-packet on PE 2
    got.delete();
    set_pe(2, 1'b1, STU_CNTL_SOM, 16'h0200);
    tick();
    set_pe(2, 1'b0, 2'b00, '0);
    tick();
    tick();
    sys__stu__ready = 1'b0;
    n   = 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (stu__pe__ready[2] && n < 6) begin
        set_pe(2, 1'b1, pkt_cntl(n, 6), 16'h0200 + 16'(n));
        n++;
      end else begin
        set_pe(2, 1'b0, 2'b00, '0);
      end
      tick();
      if (!(stu__sys__valid && stu__sys__data == 16'h0200 && stu__sys__pe_id == 3'd2 &&
            stu__sys__cntl == STU_CNTL_SOM)) bad++;
    end
    chk("t3_stable", bad, 0);
    chk("t3_accepted", n - 1, FD);
    chk("t3_ready_low", stu__pe__ready[2], 0);
    sys__stu__ready = 1'b1;
    guard = 0;
    while (n < 6 && guard < 30) begin
      if (stu__pe__ready[2]) begin
        set_pe(2, 1'b1, pkt_cntl(n, 6), 16'h0200 + 16'(n));
        n++;
      end else begin
        set_pe(2, 1'b0, 2'b00, '0);
      end
      tick();
      guard++;
    end
    set_pe(2, 1'b0, 2'b00, '0);
    chk("t3_fed", n, 6);
    wait_idle("t3", 60);
    chk("t3_count", got.size(), 6);
    for (int k = 0; k < 6; k++) chk_word("t3_w", k, 3'd2, 16'h0200 + 16'(k));

    // Orphan MOM from PE 5 is dropped and flagged
    got.delete();
    set_pe(5, 1'b1, STU_CNTL_MOM, 16'h0555);
    tick();
    set_pe(5, 1'b0, 2'b00, '0);
    chk("t4_err_pre", stu__sys__proto_err, 0);
    tick();
    chk("t4_err", stu__sys__proto_err, 1);
    chk("t4_err_id", stu__sys__err_pe_id, 5);
    repeat (3) tick();
    chk("t4_dropped", got.size(), 0);
    chk("t4_idle", stu__sys__idle, 1);
    set_pe(5, 1'b1, STU_CNTL_SOM_EOM, 16'h0556);
    tick();
    set_pe(5, 1'b0, 2'b00, '0);
    wait_idle("t4", 30);
    chk("t4_count", got.size(), 1);
    chk_word("t4_w", 0, 3'd5, 16'h0556);
    chk("t4_err_sticky", stu__sys__proto_err, 1);

    // Reset on the second word of a 4-word packet from PE 6
    got.delete();
    for (int k = 0; k < 4; k++) begin
      set_pe(6, 1'b1, pkt_cntl(k, 4), 16'h0600 + 16'(k));
      tick();
    end
    set_pe(6, 1'b0, 2'b00, '0);
    chk("t5_second", stu__sys__data, 16'h0601);
    reset_poweron = 1'b1;
    #1;
    chk("t5_rst_valid", stu__sys__valid, 0);
    chk("t5_rst_data", stu__sys__data, 0);
    chk("t5_rst_err", stu__sys__proto_err, 0);
    chk("t5_rst_ready", stu__pe__ready, 0);
    tick();
    reset_poweron = 1'b0;
    tick();
    chk("t5_idle", stu__sys__idle, 1);
    chk("t5_ready", stu__pe__ready, 8'hFF);
    got.delete();
    set_pe(6, 1'b1, STU_CNTL_SOM_EOM, 16'h0677);
    tick();
    set_pe(6, 1'b0, 2'b00, '0);
    wait_idle("t5", 30);
    chk("t5_count", got.size(), 1);
    chk_word("t5_w", 0, 3'd6, 16'h0677);

    // PEs 0..3 request continuously: grants rotate
    got.delete();
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (stu__pe__ready[p]) set_pe(p, 1'b1, STU_CNTL_SOM_EOM, 16'h0300 + 16'(p));
        else                   set_pe(p, 1'b0, 2'b00, '0);
      end
      tick();
    end
    for (int p = 0; p < 4; p++) set_pe(p, 1'b0, 2'b00, '0);
    wait_idle("t6", 300);
    chk("t6_enough", got.size() >= 5, 1);
    for (int k = 0; k < 5; k++) chk_word("t6_rot", k, 3'(k % 4), 16'h0300 + 16'(k % 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
